serial_twos_negator: RTL and testbench
======================================

Name: serial_twos_negator

Overview:
- Bit-serial, handshaked two's-complement negator. Accepts one WIDTH-bit word, processes it LSB-first over WIDTH cycles, and returns -x.
- The algorithm copies bits up to and including the first 1, then inverts every later bit.
- It is the arithmetic counterpart to the combinational bitwise inverter in the datapath. It recovers signed negation (inverse plus one) with one flop-per-bit datapath and no adder.
- It sits between a producer and a consumer, each using a valid/ready handshake.

Parameters:
- WIDTH, 16, word width in bits (must be at least 2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  block can accept a word (high only in IDLE)
- in_data  input  WIDTH  operand x, two's complement
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  result -x mod 2^WIDTH
- out_overflow  output  1  input was the most-negative value (result equals input)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; asserting it forces the reset state immediately, regardless of clk.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - out_data = 0, out_overflow = 0.
  - Shift register, counter and seen_one flag all 0.
- States:
  - IDLE: in_ready = 1. On the edge where in_valid && in_ready:
    - load in_data into the shift register;
    - clear the counter and seen_one;
    - set ovf_cand = (in_data == {1'b1, {WIDTH-1{1'b0}}});
    - go to SHIFT.
  - SHIFT: in_ready = 0. Each edge processes the LSB b:
    - result bit = seen_one ? ~b : b;
    - seen_one <= seen_one | b;
    - the result bit shifts in at the MSB of the result register; the operand shifts right;
    - the counter increments.
    - On the edge where counter == WIDTH-1, register out_data and out_overflow = ovf_cand, and go to DONE.
  - DONE: out_valid = 1. Hold out_data and out_overflow stable while !out_ready. On the edge where out_ready is high, go to IDLE and drop out_valid.
- Latency: out_valid rises exactly WIDTH edges after the accept edge (16 for the default). Throughput is one word per WIDTH+2 cycles minimum.
- No overlap: a new word is never accepted in SHIFT or DONE. in_data and in_valid are ignored outside IDLE.
- Zero input produces zero output with out_overflow = 0.
- out_ready in IDLE or SHIFT has no effect.
- Reset during SHIFT or DONE discards the word in flight. in_ready is 1 and out_valid is 0 after reset, with no spurious output.

Optional Feature:
- Macro: NEG_MODE_SEL_EN.
- Defined:
  - Adds input port mode (1 bit), sampled on the accept edge.
  - mode = 1 selects one's complement: every bit is inverted, seen_one is ignored, out_overflow is forced to 0.
  - mode = 0 selects two's complement. Latency is identical in both modes.
- Undefined: no mode port; the block always performs two's complement.

Decomposition:
- Shared header neg_defs.vh:
  - default WIDTH and CNT_W;
  - state encodings IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  - the most-negative-value constant.
- One sub-module, twos_bit_cell:
  - inputs: b, seen_in, and mode (present only when NEG_MODE_SEL_EN is defined);
  - outputs: r, seen_out;
  - purely combinational.
- The top level owns the FSM, counter, shift registers and seen_one flop.

Test Plan:
- Accept 16'h0001 with out_ready = 1 -> out_data = 16'hFFFF, out_overflow = 0, out_valid 16 edges after accept, high for 1 cycle.
- Accept 16'h0000 -> out_data = 16'h0000, out_overflow = 0. Accept 16'h7FFF -> out_data = 16'h8001.
- Accept 16'h8000 -> out_data = 16'h8000, out_overflow = 1.
- Accept 16'hFFFF with out_ready held low 5 cycles after out_valid, and in_valid held high throughout -> out_data = 16'h0001 stable across the stall; no second accept until the edge after the out handshake.
- Accept 16'h1234, assert rst asynchronously 7 cycles into SHIFT -> out_valid = 0 and in_ready = 1 immediately. Next word 16'h0002 -> 16'hFFFE.
- With NEG_MODE_SEL_EN defined, accept 16'h00F0 with mode = 1 -> 16'hFF0F, out_overflow = 0. Accept 16'h8000 with mode = 1 -> 16'h7FFF, out_overflow = 0.

Source files
------------

// File: rtl/serial_twos_negator_pkg.sv
// Shared definitions for the bit-serial negator: default sizes, FSM encoding
// and the most-negative operand value that negates to itself.
package serial_twos_negator_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [DEF_WIDTH-1:0] DEF_MOST_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/serial_twos_negator_bit_cell.sv
// One step of the serial negation: pass bits until the first 1 has been seen,
// invert afterwards. With NEG_MODE_SEL_EN, mode=1 inverts every bit.
module twos_bit_cell (
    input  logic b,
    input  logic seen_in,
`ifdef NEG_MODE_SEL_EN
    input  logic mode,
`endif
    output logic r,
    output logic seen_out
);

`ifdef NEG_MODE_SEL_EN
    assign r = b ^ (seen_in | mode);
`else
    assign r = b ^ seen_in;
`endif
    assign seen_out = seen_in | b;

endmodule

// File: rtl/serial_twos_negator.sv
// Bit-serial two's-complement negator with valid/ready on both sides.
// Optional NEG_MODE_SEL_EN adds a mode input selecting one's complement.
module serial_twos_negator
    import serial_twos_negator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef NEG_MODE_SEL_EN
    input  logic             mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_overflow
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               seen_q;
    logic               ovf_cand_q;
    logic               bit_r;
    logic               seen_nxt;
    logic               last_bit;
    logic               ovf_final;
    logic [WIDTH-1:0]   res_nxt;

`ifdef NEG_MODE_SEL_EN
    logic mode_q;

    twos_bit_cell u_cell (
        .b        (opnd_q[0]),
        .seen_in  (seen_q),
        .mode     (mode_q),
        .r        (bit_r),
        .seen_out (seen_nxt)
    );

    assign ovf_final = ovf_cand_q & ~mode_q;
`else
    twos_bit_cell u_cell (
        .b        (opnd_q[0]),
        .seen_in  (seen_q),
        .r        (bit_r),
        .seen_out (seen_nxt)
    );

    assign ovf_final = ovf_cand_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign last_bit  = (cnt_q == LAST_CNT);
    assign res_nxt   = {bit_r, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand shifts right one bit per SHIFT cycle; result fills from the MSB
    // so the first processed bit lands at bit 0 after WIDTH steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd_q       <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            seen_q       <= 1'b0;
            ovf_cand_q   <= 1'b0;
            out_data     <= '0;
            out_overflow <= 1'b0;
`ifdef NEG_MODE_SEL_EN
            mode_q       <= 1'b0;
`endif
        end else if (state_q == IDLE && in_valid) begin
            opnd_q     <= in_data;
            res_q      <= '0;
            cnt_q      <= '0;
            seen_q     <= 1'b0;
            ovf_cand_q <= (in_data == MOST_NEG);
`ifdef NEG_MODE_SEL_EN
            mode_q     <= mode;
`endif
        end else if (state_q == SHIFT) begin
            opnd_q <= opnd_q >> 1;
            res_q  <= res_nxt;
            seen_q <= seen_nxt;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                out_data     <= res_nxt;
                out_overflow <= ovf_final;
            end
        end
    end

endmodule

// File: tb/tb_serial_twos_negator.sv
// Scoreboard bench for serial_twos_negator; mode tests run when NEG_MODE_SEL_EN is defined.
module tb_serial_twos_negator;

    typedef struct packed {
        logic [15:0] data;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_overflow;
`ifdef NEG_MODE_SEL_EN
    logic        mode;
`endif

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_twos_negator #(.WIDTH(16), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
`ifdef NEG_MODE_SEL_EN
        .mode         (mode),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow)
    );

    function automatic exp_t model(input logic [15:0] x, input logic m);
        exp_t e;
        e.data = m ? ~x : (~x + 16'd1);
        e.ovf  = !m && (x == 16'h8000);
        return e;
    endfunction

    task automatic accept_word(input logic [15:0] x, input logic m, input logic keep);
        @(negedge clk);
        in_data  = x;
        in_valid = 1'b1;
`ifdef NEG_MODE_SEL_EN
        mode = m;
`endif
        exp_q.push_back(model(x, m));
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef NEG_MODE_SEL_EN
        mode = 1'b0;
`endif
        #2;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        n_cmp++;
        if (out_data !== 16'h0000 || out_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: out_data=%h ovf=%b, required 0000/0", out_data, out_overflow);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic;
        exp_t e;
        int   lat;
        out_ready = 1'b1;
        accept_word(16'h0001, 1'b0, 1'b0);
        wait_out(lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat != 16) begin
            n_err++;
            $display("FAIL basic_latency: got %0d edges, required 16", lat);
        end
        n_cmp++;
        if (out_data !== e.data || out_overflow !== e.ovf) begin
            n_err++;
            $display("FAIL basic_data: got %h/%b, required %h/%b", out_data, out_overflow, e.data, e.ovf);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_one_cycle: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_values;
        logic [15:0] vals [3];
        exp_t e;
        int   lat;
        vals[0] = 16'h0000; vals[1] = 16'h7FFF; vals[2] = 16'h8000;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            accept_word(vals[i], 1'b0, 1'b0);
            wait_out(lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (lat != 16 || out_data !== e.data || out_overflow !== e.ovf) begin
                n_err++;
                $display("FAIL value_%h: got %h/%b lat %0d, required %h/%b lat 16",
                         vals[i], out_data, out_overflow, lat, e.data, e.ovf);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall;
        exp_t e;
        int   lat;
        out_ready = 1'b0;
        accept_word(16'hFFFF, 1'b0, 1'b1);
        wait_out(lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat != 16 || out_data !== e.data || out_overflow !== e.ovf) begin
            n_err++;
            $display("FAIL stall_first: got %h/%b lat %0d, required %h/%b lat 16",
                     out_data, out_overflow, lat, e.data, e.ovf);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.data) begin
                n_err++;
                $display("FAIL stall_hold_%0d: out_valid=%b in_ready=%b data=%h, required 1/0/%h",
                         i, out_valid, in_ready, out_data, e.data);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        exp_q.push_back(model(16'hFFFF, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_reaccept: in_ready=%b, required 0", in_ready);
        end
        wait_out(lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat != 16 || out_data !== e.data) begin
            n_err++;
            $display("FAIL stall_second: got %h lat %0d, required %h lat 16", out_data, lat, e.data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        exp_t e;
        int   lat;
        out_ready = 1'b1;
        accept_word(16'h1234, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        @(negedge clk); rst = 1'b0;
        n_cmp++;
        if (out_data !== 16'h0000 || out_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_out: got %h/%b, required 0000/0", out_data, out_overflow);
        end
        accept_word(16'h0002, 1'b0, 1'b0);
        wait_out(lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat != 16 || out_data !== e.data || out_overflow !== e.ovf) begin
            n_err++;
            $display("FAIL after_reset_word: got %h/%b lat %0d, required %h/%b lat 16",
                     out_data, out_overflow, lat, e.data, e.ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        exp_t        e;
        int          lat;
        logic [15:0] x;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x = 16'($urandom);
            accept_word(x, 1'b0, 1'b0);
            wait_out(lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (lat != 16 || out_data !== e.data || out_overflow !== e.ovf) begin
                n_err++;
                $display("FAIL b2b_%0d x=%h: got %h/%b lat %0d, required %h/%b lat 16",
                         i, x, out_data, out_overflow, lat, e.data, e.ovf);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef NEG_MODE_SEL_EN
    task automatic test_mode;
        logic [15:0] vals [3];
        logic        ms   [3];
        exp_t        e;
        int          lat;
        vals[0] = 16'h00F0; ms[0] = 1'b1;
        vals[1] = 16'h8000; ms[1] = 1'b1;
        vals[2] = 16'h8000; ms[2] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            accept_word(vals[i], ms[i], 1'b0);
            mode = ~ms[i];
            wait_out(lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (lat != 16 || out_data !== e.data || out_overflow !== e.ovf) begin
                n_err++;
                $display("FAIL mode_%0d x=%h m=%b: got %h/%b lat %0d, required %h/%b lat 16",
                         i, vals[i], ms[i], out_data, out_overflow, lat, e.data, e.ovf);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_stall();
        test_async_reset();
        test_back_to_back();
`ifdef NEG_MODE_SEL_EN
        test_mode();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
